// File: rtl/div_pkg.sv
// Shared types and sizing for the div_sched iterative signed divider.
package div_pkg;

    // Default operand width and the quantities derived from it
    localparam int DIV_WIDTH = 8;
    localparam int DIV_CNT_W = $clog2(DIV_WIDTH);
    localparam int DIV_Q_W   = DIV_WIDTH + 1;

    // Controller states of the shared long-division datapath
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Identifies one of the two requesters
    typedef logic req_id_t;

endpackage

// File: rtl/div_sched_rr_arb2.sv
// Two-way round-robin arbiter: combinational grant plus the preference pointer.
module rr_arb2
    import div_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_req,
    input  logic       i_advance,
    input  req_id_t    i_served,
    output logic [1:0] o_grant
);

    logic r_ptr;

    // Pointer names the requester that wins a tie; after a service it points away from the one served
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= 1'b0;
        end else if (i_advance) begin
            r_ptr <= ~i_served;
        end
    end

    // Single requester always wins; on a tie the pointer decides
    always_comb begin
        o_grant = i_req;
        if (i_req == 2'b11) begin
            o_grant = r_ptr ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/div_sched.sv
// div_sched: restoring signed divider (one quotient bit per clock) shared by two
// requesters through a round-robin front end, valid/ready on both sides.
// Optional feature macro: DIV_ZERO_DETECT_EN adds the dz output and a 1-clock
// divide-by-zero shortcut; without it a zero divisor runs the normal algorithm.
module div_sched
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH:0]   q,
    output logic [WIDTH-1:0] r,
`ifdef DIV_ZERO_DETECT_EN
    output logic             dz,
`endif
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH);

    state_t           r_state;
    state_t           w_state_next;
    logic [1:0]       w_grant;
    logic             w_accept;
    logic             w_advance;
    req_id_t          w_sel;
    req_id_t          w_served;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH-1:0] w_diff;
    logic             w_ge;

    req_id_t          r_id;
    logic [WIDTH-1:0] r_abs_a;
    logic [WIDTH-1:0] r_abs_b;
    logic             r_sa;
    logic             r_sb;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH:0]   r_quo;
    logic [CNT_W-1:0] r_idx;
`ifdef DIV_ZERO_DETECT_EN
    logic             w_b_zero;
    logic             r_dz;
`endif

    // During a division the pointer update names the stored id; the zero shortcut updates at acceptance
    assign w_served = (r_state == IDLE) ? w_sel : r_id;

    rr_arb2 u_arb (
        .clk       (clk),
        .rst       (rst),
        .i_req     (req_valid),
        .i_advance (w_advance),
        .i_served  (w_served),
        .o_grant   (w_grant)
    );

    assign w_sel   = w_grant[1];
    assign w_a     = w_sel ? a1 : a0;
    assign w_b     = w_sel ? b1 : b0;
    // Magnitudes are unsigned, so the most negative operand maps to its own bit pattern
    assign w_abs_a = w_a[WIDTH-1] ? -w_a : w_a;
    assign w_abs_b = w_b[WIDTH-1] ? -w_b : w_b;
`ifdef DIV_ZERO_DETECT_EN
    assign w_b_zero = (w_b == '0);
`endif

    // Shifted partial remainder can reach 2*|b|-1, so compare one bit wider;
    // the difference itself always fits in WIDTH bits when it is taken
    assign w_shift = {r_rem, r_abs_a[r_idx]};
    assign w_ge    = (w_shift >= {1'b0, r_abs_b});
    assign w_diff  = w_shift[WIDTH-1:0] - r_abs_b;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state, handshake outputs and pointer advance
    always_comb begin
        w_state_next = r_state;
        req_ready    = 2'b00;
        w_accept     = 1'b0;
        w_advance    = 1'b0;
        case (r_state)
            IDLE: begin
                req_ready = rst ? 2'b00 : w_grant;
                w_accept  = |w_grant;
                if (w_accept) begin
                    w_state_next = RUN;
`ifdef DIV_ZERO_DETECT_EN
                    if (w_b_zero) begin
                        w_state_next = DONE;
                        w_advance    = 1'b1;
                    end
`endif
                end
            end
            RUN: begin
                if (r_idx == '0) begin
                    w_state_next = FIX;
                end
            end
            FIX: begin
                w_state_next = DONE;
                w_advance    = 1'b1;
            end
            DONE: begin
                if (rsp_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Datapath: latch operands on acceptance, one restoring step per RUN clock, sign fix-up in FIX
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_id    <= 1'b0;
            r_abs_a <= '0;
            r_abs_b <= '0;
            r_sa    <= 1'b0;
            r_sb    <= 1'b0;
            r_rem   <= '0;
            r_quo   <= '0;
            r_idx   <= '0;
`ifdef DIV_ZERO_DETECT_EN
            r_dz    <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_id    <= w_sel;
                        r_abs_a <= w_abs_a;
                        r_abs_b <= w_abs_b;
                        r_sa    <= w_a[WIDTH-1];
                        r_sb    <= w_b[WIDTH-1];
                        r_rem   <= '0;
                        r_quo   <= '0;
                        r_idx   <= CNT_W'(WIDTH - 1);
`ifdef DIV_ZERO_DETECT_EN
                        r_dz    <= w_b_zero;
                        if (w_b_zero) begin
                            r_rem <= w_a;
                        end
`endif
                    end
                end
                RUN: begin
                    r_rem        <= w_ge ? w_diff : w_shift[WIDTH-1:0];
                    r_quo[r_idx] <= w_ge;
                    r_idx        <= r_idx - CNT_W'(1);
                end
                FIX: begin
                    if (r_sa ^ r_sb) begin
                        r_quo <= -r_quo;
                    end
                    if ((r_rem != '0) && r_sa) begin
                        r_rem <= -r_rem;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign q         = r_quo;
    assign r         = r_rem;
    assign rsp_id    = r_id;
    assign rsp_valid = (r_state == DONE);
    assign busy      = (r_state != IDLE);
`ifdef DIV_ZERO_DETECT_EN
    assign dz        = r_dz;
`endif

endmodule

// File: tb/tb_div_sched.sv
// Directed bench for div_sched: reset, arithmetic, round-robin, back-pressure,
// asynchronous reset mid-division and divide by zero (both builds of DIV_ZERO_DETECT_EN).
module tb_div_sched;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] req_valid = 2'b00;
    logic [1:0] req_ready;
    logic [7:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic       rsp_id;
    logic [8:0] q;
    logic [7:0] r;
    logic       busy;
`ifdef DIV_ZERO_DETECT_EN
    logic       dz;
`endif

    int checks = 0;
    int errors = 0;

    div_sched dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .a0        (a0),
        .b0        (b0),
        .a1        (a1),
        .b1        (b1),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .q         (q),
        .r         (r),
`ifdef DIV_ZERO_DETECT_EN
        .dz        (dz),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Present operands for one requester and raise its valid
    task automatic drive(input int id, input logic [7:0] a, input logic [7:0] b);
        if (id == 0) begin a0 = a; b0 = b; end
        else begin a1 = a; b1 = b; end
        req_valid[id] = 1'b1;
    endtask

    // Wait (bounded) until requester id is granted; returns at the negedge after the accept edge
    task automatic accept_wait(input int id, output bit ok);
        ok = 1'b0;
        #1;
        for (int k = 0; k < 20; k++) begin
            if (req_ready[id] === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
            #1;
        end
        @(negedge clk);
        req_valid[id] = 1'b0;
    endtask

    // Count clock edges after the accept edge until rsp_valid is seen (bounded)
    task automatic wait_rsp(output int lat);
        lat = 0;
        while (rsp_valid !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        req_valid = 2'b11;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (q !== 9'h000 || r !== 8'h00) begin
            errors++;
            $display("FAIL reset_qr got q=%h r=%h want q=000 r=00", q, r);
        end
        checks++;
        if (rsp_valid !== 1'b0 || rsp_id !== 1'b0 || busy !== 1'b0 || req_ready !== 2'b00) begin
            errors++;
            $display("FAIL reset_ctrl got rsp_valid=%b rsp_id=%b busy=%b req_ready=%b want 0 0 0 00",
                     rsp_valid, rsp_id, busy, req_ready);
        end
`ifdef DIV_ZERO_DETECT_EN
        checks++;
        if (dz !== 1'b0) begin
            errors++;
            $display("FAIL reset_dz got %b want 0", dz);
        end
`endif
        $display("txn reset q=%h r=%h busy=%b req_ready=%b", q, r, busy, req_ready);
        req_valid = 2'b00;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        bit ok;
        int lat;
        drive(0, 8'd100, 8'd7);
        accept_wait(0, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL basic_accept got req_ready=%b want bit0 granted", req_ready);
        end
        wait_rsp(lat);
        checks++;
        if (lat !== 9) begin
            errors++;
            $display("FAIL basic_latency got %0d want 9", lat);
        end
        checks++;
        if (q !== 9'd14 || r !== 8'd2 || rsp_id !== 1'b0) begin
            errors++;
            $display("FAIL basic_result got q=%h r=%h id=%b want q=00e r=02 id=0", q, r, rsp_id);
        end
`ifdef DIV_ZERO_DETECT_EN
        checks++;
        if (dz !== 1'b0) begin
            errors++;
            $display("FAIL basic_dz got %b want 0", dz);
        end
`endif
        $display("txn basic id=0 a=100 b=7 q=%h r=%h lat=%0d", q, r, lat);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_release got rsp_valid=%b busy=%b want 0 0", rsp_valid, busy);
        end
    endtask

    task automatic test_signed();
        bit ok;
        int lat;
        logic [7:0] ta, tb;
        logic [8:0] eq;
        logic [7:0] er;
        for (int k = 0; k < 2; k++) begin
            if (k == 0) begin ta = 8'h9C; tb = 8'd7;  eq = 9'h1F2; er = 8'hFE; end
            else        begin ta = 8'h80; tb = 8'hFF; eq = 9'h080; er = 8'h00; end
            drive(k, ta, tb);
            accept_wait(k, ok);
            wait_rsp(lat);
            checks++;
            if (!ok || lat !== 9) begin
                errors++;
                $display("FAIL signed_timing k=%0d got ok=%0d lat=%0d want 1 9", k, ok, lat);
            end
            checks++;
            if (q !== eq || r !== er || rsp_id !== k[0]) begin
                errors++;
                $display("FAIL signed_result k=%0d got q=%h r=%h id=%b want q=%h r=%h id=%0d",
                         k, q, r, rsp_id, eq, er, k);
            end
            $display("txn signed id=%0d a=%h b=%h q=%h r=%h", k, ta, tb, q, r);
            rsp_ready = 1'b1;
            @(negedge clk);
            rsp_ready = 1'b0;
        end
    endtask

    task automatic test_rr();
        bit ok;
        int lat;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        // Round 1: both valid out of reset -> 0 first
        drive(0, 8'd9, 8'd3);
        drive(1, 8'd20, 8'd6);
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            errors++;
            $display("FAIL rr_first got req_ready=%b want 01", req_ready);
        end
        accept_wait(0, ok);
        checks++;
        if (req_ready !== 2'b00) begin
            errors++;
            $display("FAIL rr_ready_busy got req_ready=%b want 00", req_ready);
        end
        wait_rsp(lat);
        checks++;
        if (q !== 9'd3 || r !== 8'd0 || rsp_id !== 1'b0) begin
            errors++;
            $display("FAIL rr_res0 got q=%h r=%h id=%b want 003 00 0", q, r, rsp_id);
        end
        $display("txn rr id=0 a=9 b=3 q=%h r=%h", q, r);
        // Handshake with both valid pending: nothing granted this cycle
        rsp_ready = 1'b1;
        drive(0, 8'hF7, 8'd2);
        #1;
        checks++;
        if (req_ready !== 2'b00) begin
            errors++;
            $display("FAIL rr_hs_cycle got req_ready=%b want 00", req_ready);
        end
        @(negedge clk);
        rsp_ready = 1'b0;
        checks++;
        if (req_ready !== 2'b10) begin
            errors++;
            $display("FAIL rr_second got req_ready=%b want 10", req_ready);
        end
        accept_wait(1, ok);
        wait_rsp(lat);
        checks++;
        if (q !== 9'd3 || r !== 8'd2 || rsp_id !== 1'b1) begin
            errors++;
            $display("FAIL rr_res1 got q=%h r=%h id=%b want 003 02 1", q, r, rsp_id);
        end
        $display("txn rr id=1 a=20 b=6 q=%h r=%h", q, r);
        // Round 2: both valid again -> 0 then 1
        rsp_ready = 1'b1;
        drive(1, 8'd17, 8'hFB);
        @(negedge clk);
        rsp_ready = 1'b0;
        checks++;
        if (req_ready !== 2'b01) begin
            errors++;
            $display("FAIL rr_third got req_ready=%b want 01", req_ready);
        end
        accept_wait(0, ok);
        wait_rsp(lat);
        checks++;
        if (q !== 9'h1FC || r !== 8'hFF || rsp_id !== 1'b0) begin
            errors++;
            $display("FAIL rr_res2 got q=%h r=%h id=%b want 1fc ff 0", q, r, rsp_id);
        end
        $display("txn rr id=0 a=f7 b=02 q=%h r=%h", q, r);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        checks++;
        if (req_ready !== 2'b10) begin
            errors++;
            $display("FAIL rr_fourth got req_ready=%b want 10", req_ready);
        end
        accept_wait(1, ok);
        wait_rsp(lat);
        checks++;
        if (q !== 9'h1FD || r !== 8'h02 || rsp_id !== 1'b1) begin
            errors++;
            $display("FAIL rr_res3 got q=%h r=%h id=%b want 1fd 02 1", q, r, rsp_id);
        end
        $display("txn rr id=1 a=11 b=fb q=%h r=%h", q, r);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        bit ok;
        int lat;
        drive(1, 8'd50, 8'hF9);
        accept_wait(1, ok);
        drive(0, 8'd3, 8'd1);
        wait_rsp(lat);
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (rsp_valid !== 1'b1 || q !== 9'h1F9 || r !== 8'h01 || rsp_id !== 1'b1 || req_ready !== 2'b00) begin
                errors++;
                $display("FAIL bp_hold k=%0d got v=%b q=%h r=%h id=%b rdy=%b want 1 1f9 01 1 00",
                         k, rsp_valid, q, r, rsp_id, req_ready);
            end
            @(negedge clk);
        end
        $display("txn backpressure id=1 a=50 b=f9 q=%h r=%h", q, r);
        rsp_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 2'b00) begin
            errors++;
            $display("FAIL bp_hs_cycle got req_ready=%b want 00", req_ready);
        end
        @(negedge clk);
        rsp_ready = 1'b0;
        checks++;
        if (busy !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 2'b01 || q !== 9'h1F9) begin
            errors++;
            $display("FAIL bp_idle got busy=%b v=%b rdy=%b q=%h want 0 0 01 1f9", busy, rsp_valid, req_ready, q);
        end
        req_valid = 2'b00;
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        bit ok;
        int lat;
        drive(1, 8'd127, 8'd1);
        accept_wait(1, ok);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || rsp_id !== 1'b1) begin
            errors++;
            $display("FAIL arst_pre got busy=%b id=%b want 1 1", busy, rsp_id);
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if (q !== 9'h000 || r !== 8'h00 || rsp_valid !== 1'b0 || rsp_id !== 1'b0 || busy !== 1'b0 || req_ready !== 2'b00) begin
            errors++;
            $display("FAIL arst_clear got q=%h r=%h v=%b id=%b busy=%b rdy=%b want all 0",
                     q, r, rsp_valid, rsp_id, busy, req_ready);
        end
        $display("txn async_reset id=1 q=%h r=%h busy=%b", q, r, busy);
        @(negedge clk);
        rst = 1'b0;
        drive(0, 8'd100, 8'd7);
        accept_wait(0, ok);
        wait_rsp(lat);
        checks++;
        if (lat !== 9 || q !== 9'd14 || r !== 8'd2 || rsp_id !== 1'b0) begin
            errors++;
            $display("FAIL arst_after got lat=%0d q=%h r=%h id=%b want 9 00e 02 0", lat, q, r, rsp_id);
        end
        $display("txn after_reset id=0 a=100 b=7 q=%h r=%h lat=%0d", q, r, lat);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_div_zero();
        bit ok;
        int lat;
        logic [7:0] ta;
        logic [8:0] eq;
        logic [7:0] er;
        int el;
        for (int k = 0; k < 2; k++) begin
            ta = (k == 0) ? 8'h05 : 8'hFB;
`ifdef DIV_ZERO_DETECT_EN
            eq = 9'h000; er = ta; el = 0;
`else
            eq = (k == 0) ? 9'h0FF : 9'h101;
            er = ta;
            el = 9;
`endif
            drive(0, ta, 8'h00);
            accept_wait(0, ok);
            wait_rsp(lat);
            checks++;
            if (!ok || lat !== el) begin
                errors++;
                $display("FAIL dz_latency k=%0d got ok=%0d lat=%0d want 1 %0d", k, ok, lat, el);
            end
            checks++;
            if (q !== eq || r !== er) begin
                errors++;
                $display("FAIL dz_result k=%0d got q=%h r=%h want q=%h r=%h", k, q, r, eq, er);
            end
`ifdef DIV_ZERO_DETECT_EN
            checks++;
            if (dz !== 1'b1) begin
                errors++;
                $display("FAIL dz_flag k=%0d got %b want 1", k, dz);
            end
`endif
            $display("txn div_zero id=0 a=%h b=00 q=%h r=%h lat=%0d", ta, q, r, lat);
            rsp_ready = 1'b1;
            @(negedge clk);
            rsp_ready = 1'b0;
        end
        // A normal division afterwards must report a clean result
        drive(1, 8'd12, 8'd5);
        accept_wait(1, ok);
        wait_rsp(lat);
        checks++;
        if (q !== 9'd2 || r !== 8'd2 || lat !== 9) begin
            errors++;
            $display("FAIL dz_after got q=%h r=%h lat=%0d want 002 02 9", q, r, lat);
        end
`ifdef DIV_ZERO_DETECT_EN
        checks++;
        if (dz !== 1'b0) begin
            errors++;
            $display("FAIL dz_after_flag got %b want 0", dz);
        end
`endif
        $display("txn after_zero id=1 a=12 b=5 q=%h r=%h", q, r);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signed();
        test_rr();
        test_backpressure();
        test_async_reset();
        test_div_zero();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
